// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with two combinational read ports, one clocked
// write port, optional hard-wired zero register, optional same-cycle
// write-to-read bypass, and a per-register scoreboard of pending writes.
module reg_file_sb #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  output logic [DATA_W-1:0]   read_data1,
  output logic [DATA_W-1:0]   read_data2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  input  logic                alloc_en,
  input  logic [ADDR_W-1:0]   alloc_rd,
  output logic                alloc_ready,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                alloc_err
);

  localparam bit LP_ZERO   = (ZERO_REG != 0);
  localparam bit LP_BYPASS = (BYPASS != 0);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_alloc_err;

  logic w_wv;
  logic w_alloc_zero;
  logic w_alloc_ready;
  logic w_av;

  // Read mux in priority order: reset, zero register, bypass, array.
  function automatic logic [DATA_W-1:0] f_rd_mux(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              rst_n,
    input logic              wv,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if (!rst_n)
      return '0;
    else if (LP_ZERO && (a == '0))
      return '0;
    else if (LP_BYPASS && wv && (wa == a))
      return wd;
    else
      return stored;
  endfunction

  // Busy flag for a read port; a same-cycle writeback hides it when bypassing.
  function automatic logic f_busy(
    input logic [ADDR_W-1:0] a,
    input logic              busy_bit,
    input logic              rst_n,
    input logic              wv,
    input logic [ADDR_W-1:0] wa
  );
    if (!rst_n)
      return 1'b0;
    else if (LP_BYPASS && wv && (wa == a))
      return 1'b0;
    else
      return busy_bit;
  endfunction

  // Writes to r0 are dropped when it is hard-wired to zero.
  assign w_wv          = wr_en && !(LP_ZERO && (wr_addr == '0));
  assign w_alloc_zero  = LP_ZERO && (alloc_rd == '0);
  // A reservation may be taken in the same cycle the previous one retires.
  assign w_alloc_ready = w_alloc_zero || !r_busy[alloc_rd] ||
                         (w_wv && (wr_addr == alloc_rd));
  assign w_av          = alloc_en && w_alloc_ready && !w_alloc_zero;

  assign alloc_ready = w_alloc_ready;
  assign busy_vec    = r_busy;
  assign alloc_err   = r_alloc_err;

  assign read_data1 = f_rd_mux(rs1, r_regs[rs1], reset, w_wv, wr_addr, wr_data);
  assign read_data2 = f_rd_mux(rs2, r_regs[rs2], reset, w_wv, wr_addr, wr_data);
  assign rs1_busy   = f_busy(rs1, r_busy[rs1], reset, w_wv, wr_addr);
  assign rs2_busy   = f_busy(rs2, r_busy[rs2], reset, w_wv, wr_addr);

  // Register array: cleared on reset, written on a valid writeback.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wv) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard: writeback clears, allocation sets (allocation wins on a tie).
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      if (w_wv) r_busy[wr_addr] <= 1'b0;
      if (w_av) r_busy[alloc_rd] <= 1'b1;
    end
  end

  // Sticky error for any allocation attempted while not ready.
  always_ff @(posedge clk) begin
    if (!reset)
      r_alloc_err <= 1'b0;
    else if (alloc_en && !w_alloc_ready)
      r_alloc_err <= 1'b1;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: table-driven vectors on the default
// configuration, plus hand sequences for BYPASS=0 and a 32x16, no-zero-reg
// configuration.
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared inputs for the 64x32 instances (BYPASS=1 and BYPASS=0)
  logic        reset;
  logic [4:0]  rs1, rs2, alloc_rd, wr_addr;
  logic        alloc_en, wr_en;
  logic [63:0] wr_data;

  logic [63:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_b1, a_b2, b_b1, b_b2, a_rdy, b_rdy, a_err, b_err;
  logic [31:0] a_bv, b_bv;

  // Inputs/outputs for the 32x16 instance
  logic        c_reset;
  logic [3:0]  c_rs1, c_rs2, c_ard, c_wa;
  logic        c_ae, c_we;
  logic [31:0] c_wd, c_rd1, c_rd2;
  logic        c_b1, c_b2, c_rdy, c_err;
  logic [15:0] c_bv;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_sb u_a (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .read_data1(a_rd1), .read_data2(a_rd2), .rs1_busy(a_b1), .rs2_busy(a_b2),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .alloc_ready(a_rdy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_vec(a_bv), .alloc_err(a_err)
  );

  reg_file_sb #(.BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .read_data1(b_rd1), .read_data2(b_rd2), .rs1_busy(b_b1), .rs2_busy(b_b2),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .alloc_ready(b_rdy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_vec(b_bv), .alloc_err(b_err)
  );

  reg_file_sb #(.DATA_W(32), .NUM_REGS(16), .ZERO_REG(0)) u_c (
    .clk(clk), .reset(c_reset), .rs1(c_rs1), .rs2(c_rs2),
    .read_data1(c_rd1), .read_data2(c_rd2), .rs1_busy(c_b1), .rs2_busy(c_b2),
    .alloc_en(c_ae), .alloc_rd(c_ard), .alloc_ready(c_rdy),
    .wr_en(c_we), .wr_addr(c_wa), .wr_data(c_wd),
    .busy_vec(c_bv), .alloc_err(c_err)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  rs1, rs2;
    logic        ae;
    logic [4:0]  ard;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [63:0] e_rd1, e_rd2;
    logic        e_b1, e_b2, e_rdy;
    logic        chk_st;
    logic [31:0] e_bv;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic rst, input logic [4:0] r1, input logic [4:0] r2,
    input logic ae, input logic [4:0] ard,
    input logic we, input logic [4:0] wa, input logic [63:0] wd,
    input logic [63:0] e1, input logic [63:0] e2,
    input logic eb1, input logic eb2, input logic erdy,
    input logic cst, input logic [31:0] ebv, input logic eerr
  );
    vec_t v;
    v.rst = rst; v.rs1 = r1; v.rs2 = r2; v.ae = ae; v.ard = ard;
    v.we = we; v.wa = wa; v.wd = wd; v.e_rd1 = e1; v.e_rd2 = e2;
    v.e_b1 = eb1; v.e_b2 = eb2; v.e_rdy = erdy; v.chk_st = cst;
    v.e_bv = ebv; v.e_err = eerr;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    reset = 1'b0; rs1 = '0; rs2 = '0; alloc_en = 1'b0; alloc_rd = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    c_reset = 1'b0; c_rs1 = '0; c_rs2 = '0; c_ae = 1'b0; c_ard = '0;
    c_we = 1'b0; c_wa = '0; c_wd = '0;

    //  rst  rs1    rs2    ae    ard    we    wa     wd               rd1          rd2          b1    b2    rdy   chk   bv               err
    add(1'b0, 5'd5, 5'd7, 1'b1, 5'd0, 1'b1, 5'd5, 64'h99,          64'h0,       64'h0,       1'b0, 1'b0, 1'b1, 1'b0, 32'h0,           1'b0);
    add(1'b0, 5'd5, 5'd7, 1'b1, 5'd0, 1'b1, 5'd5, 64'h99,          64'h0,       64'h0,       1'b0, 1'b0, 1'b1, 1'b1, 32'h0,           1'b0);
    add(1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 1'b1, 5'd0, 64'hDEAD,        64'h0,       64'h0,       1'b0, 1'b0, 1'b1, 1'b1, 32'h0,           1'b0);
    add(1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 64'h1234,        64'h0,       64'h1234,    1'b0, 1'b0, 1'b1, 1'b1, 32'h0,           1'b0);
    add(1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0,           64'h0,       64'h1234,    1'b0, 1'b0, 1'b1, 1'b1, 32'h0,           1'b0);
    add(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 64'h0,           64'h0,       64'h0,       1'b0, 1'b0, 1'b1, 1'b1, 32'h0,           1'b0);
    add(1'b1, 5'd3, 5'd5, 1'b1, 5'd3, 1'b0, 5'd0, 64'h0,           64'h0,       64'h1234,    1'b1, 1'b0, 1'b0, 1'b1, 32'h8,           1'b0);
    add(1'b1, 5'd3, 5'd3, 1'b0, 5'd3, 1'b1, 5'd3, 64'h55,          64'h55,      64'h55,      1'b0, 1'b0, 1'b1, 1'b1, 32'h8,           1'b1);
    add(1'b1, 5'd3, 5'd3, 1'b0, 5'd3, 1'b0, 5'd0, 64'h0,           64'h55,      64'h55,      1'b0, 1'b0, 1'b1, 1'b1, 32'h0,           1'b1);
    add(1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 64'h0,           64'h0,       64'h0,       1'b0, 1'b0, 1'b1, 1'b1, 32'h0,           1'b1);
    add(1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 64'hCAFE,        64'hCAFE,    64'hCAFE,    1'b0, 1'b0, 1'b1, 1'b1, 32'h200,         1'b1);
    add(1'b1, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 5'd0, 64'h0,           64'hCAFE,    64'hCAFE,    1'b1, 1'b1, 1'b0, 1'b1, 32'h200,         1'b1);
    add(1'b1, 5'd2, 5'd4, 1'b1, 5'd2, 1'b0, 5'd0, 64'h0,           64'h0,       64'h0,       1'b0, 1'b0, 1'b1, 1'b1, 32'h200,         1'b1);
    add(1'b1, 5'd2, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0, 64'h0,           64'h0,       64'h0,       1'b1, 1'b0, 1'b1, 1'b1, 32'h204,         1'b1);
    add(1'b0, 5'd2, 5'd9, 1'b1, 5'd9, 1'b1, 5'd2, 64'h7,           64'h0,       64'h0,       1'b0, 1'b0, 1'b0, 1'b1, 32'h214,         1'b1);
    add(1'b1, 5'd2, 5'd9, 1'b0, 5'd2, 1'b1, 5'd2, 64'h1,           64'h1,       64'h0,       1'b0, 1'b0, 1'b1, 1'b1, 32'h0,           1'b0);
    add(1'b1, 5'd2, 5'd3, 1'b0, 5'd2, 1'b0, 5'd0, 64'h0,           64'h1,       64'h0,       1'b0, 1'b0, 1'b1, 1'b1, 32'h0,           1'b0);
    add(1'b1, 5'd31, 5'd0, 1'b1, 5'd31, 1'b1, 5'd31, ONES,         ONES,        64'h0,       1'b0, 1'b0, 1'b1, 1'b1, 32'h0,           1'b0);
    add(1'b1, 5'd31, 5'd31, 1'b0, 5'd31, 1'b0, 5'd0, 64'h0,        ONES,        ONES,        1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0000,   1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; rs1 = vq[i].rs1; rs2 = vq[i].rs2;
      alloc_en = vq[i].ae; alloc_rd = vq[i].ard;
      wr_en = vq[i].we; wr_addr = vq[i].wa; wr_data = vq[i].wd;
      @(negedge clk);
      chk($sformatf("v%0d read_data1", i), a_rd1, vq[i].e_rd1);
      chk($sformatf("v%0d read_data2", i), a_rd2, vq[i].e_rd2);
      chk($sformatf("v%0d rs1_busy", i), 64'(a_b1), 64'(vq[i].e_b1));
      chk($sformatf("v%0d rs2_busy", i), 64'(a_b2), 64'(vq[i].e_b2));
      chk($sformatf("v%0d alloc_ready", i), 64'(a_rdy), 64'(vq[i].e_rdy));
      if (vq[i].chk_st) begin
        chk($sformatf("v%0d busy_vec", i), 64'(a_bv), 64'(vq[i].e_bv));
        chk($sformatf("v%0d alloc_err", i), 64'(a_err), 64'(vq[i].e_err));
      end
      tick();
    end

    // Bypass on vs off: same-cycle write to r7
    alloc_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hA5A5; rs1 = 5'd7; rs2 = 5'd7;
    @(negedge clk);
    chk("byp1 rd1", a_rd1, 64'hA5A5);
    chk("byp1 rd2", a_rd2, 64'hA5A5);
    chk("nobyp rd1 old", b_rd1, 64'h0);
    chk("nobyp rd2 old", b_rd2, 64'h0);
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("nobyp rd1 next", b_rd1, 64'hA5A5);
    chk("nobyp rd2 next", b_rd2, 64'hA5A5);
    tick();

    // Writeback to busy r31: busy hidden only with bypass
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h5; rs1 = 5'd31;
    @(negedge clk);
    chk("wb byp busy", 64'(a_b1), 64'h0);
    chk("wb byp rd", a_rd1, 64'h5);
    chk("wb nobyp busy", 64'(b_b1), 64'h1);
    chk("wb nobyp rd", b_rd1, ONES);
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("nobyp busy after", 64'(b_b1), 64'h0);
    chk("nobyp rd after", b_rd1, 64'h5);
    chk("byp busy_vec after", 64'(a_bv), 64'h0);
    chk("nobyp busy_vec after", 64'(b_bv), 64'h0);
    tick();

    // 32x16 instance without zero register
    @(negedge clk);
    chk("c reset busy_vec", 64'(c_bv), 64'h0);
    chk("c reset err", 64'(c_err), 64'h0);
    chk("c reset rd1", 64'(c_rd1), 64'h0);
    tick();
    c_reset = 1'b1; c_we = 1'b1; c_wa = 4'd0; c_wd = 32'hFFFF_FFFF; c_rs1 = 4'd0;
    @(negedge clk);
    chk("c r0 bypass", 64'(c_rd1), 64'hFFFF_FFFF);
    tick();
    c_we = 1'b0; c_ae = 1'b1; c_ard = 4'd0;
    @(negedge clk);
    chk("c r0 readback", 64'(c_rd1), 64'hFFFF_FFFF);
    chk("c r0 alloc_ready", 64'(c_rdy), 64'h1);
    tick();
    c_we = 1'b1; c_wa = 4'd15; c_wd = 32'h0000_ABCD; c_rs2 = 4'd15;
    @(negedge clk);
    chk("c r0 busy", 64'(c_b1), 64'h1);
    chk("c r0 refused", 64'(c_rdy), 64'h0);
    chk("c busy_vec r0", 64'(c_bv), 64'h0001);
    chk("c r15 bypass", 64'(c_rd2), 64'h0000_ABCD);
    tick();
    c_we = 1'b0; c_ae = 1'b1; c_ard = 4'd15;
    @(negedge clk);
    chk("c err sticky", 64'(c_err), 64'h1);
    chk("c r15 readback", 64'(c_rd2), 64'h0000_ABCD);
    chk("c r15 alloc_ready", 64'(c_rdy), 64'h1);
    tick();
    c_ae = 1'b0;
    @(negedge clk);
    chk("c busy_vec r0 r15", 64'(c_bv), 64'h8001);
    chk("c r15 busy", 64'(c_b2), 64'h1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
